// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states,
// launch classification and flag bit positions.
package alu_seq_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_INC = 5'd2,
        ALU_DEC = 5'd3,
        ALU_AND = 5'd4,
        ALU_OR  = 5'd5,
        ALU_XOR = 5'd6,
        ALU_NOT = 5'd7,
        ALU_NEG = 5'd8,
        ALU_MUL = 5'd9,
        ALU_DIV = 5'd10,
        ALU_RSL = 5'd24,
        ALU_LSL = 5'd25,
        ALU_RSA = 5'd26,
        ALU_LSA = 5'd27,
        ALU_RSR = 5'd28,
        ALU_LSR = 5'd29,
        ALU_RSC = 5'd30,
        ALU_LSC = 5'd31
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // How an accepted operation proceeds after the accepting edge
    typedef enum logic [1:0] {
        LAUNCH_DONE   = 2'd0,
        LAUNCH_SHIFT  = 2'd1,
        LAUNCH_MULDIV = 2'd2
    } launch_e;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_NF = 2;
    localparam int FLAG_CF = 1;
    localparam int FLAG_OF = 0;

    // All shift/rotate codes live in the 24..31 block
    function automatic logic is_shift(input alu_op_e op);
        return (op[4:3] == 2'b11);
    endfunction

    function automatic logic [3:0] pack_flags(input logic zf, input logic nf,
                                              input logic cf, input logic of);
        logic [3:0] f;
        f          = '0;
        f[FLAG_ZF] = zf;
        f[FLAG_NF] = nf;
        f[FLAG_CF] = cf;
        f[FLAG_OF] = of;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide datapath.
// One iteration per step; done marks the step that produces the final value,
// and lo_next/hi_next expose the register contents after the current step.
module alu_muldiv
    import alu_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         is_div,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         step,
    output logic [W-1:0] lo_next,
    output logic [W-1:0] hi_next,
    output logic         done
);

    localparam int CW = $clog2(W) + 1;

    logic          mode_q, mode_d;
    logic [W-1:0]  m_q, m_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;
    logic          div_ge;

    // One multiply or divide iteration, or operand capture on load
    always_comb begin
        mode_d    = mode_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = div_shift - {1'b0, m_q};
        div_ge    = (div_shift >= {1'b0, m_q});
        if (load) begin
            mode_d = is_div;
            m_d    = op_b;
            hi_d   = '0;
            lo_d   = op_a;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            if (mode_q) begin
                hi_d = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
                lo_d = {lo_q[W-2:0], div_ge};
            end else begin
                hi_d = mul_sum[W:1];
                lo_d = {mul_sum[0], lo_q[W-1:1]};
            end
        end
    end

    assign lo_next = lo_d;
    assign hi_next = hi_d;
    assign done    = step && (cnt_q == CW'(W - 1));

    // Working registers, cleared on reset so an aborted operation leaves nothing behind
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
            m_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            m_q    <= m_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, iterative shifts/rotates
// (one bit per cycle) and an iterative multiply/divide behind a
// start/busy/ready handshake. Results are registered and held until the
// next ready pulse.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   opsel,
    input  logic [W-1:0] srcA,
    input  logic [W-1:0] srcB,
    input  logic         Cflag,
    input  logic         Oflag,
    output logic [W-1:0] res,
    output logic [W-1:0] res_hi,
    output logic [3:0]   flag_next,
    output logic         busy,
    output logic         ready
);

    localparam int SHW = $clog2(W) + 1;

    state_e         state_q, state_d;
    alu_op_e        op_q, op_d;
    logic [W-1:0]   sh_v_q, sh_v_d;
    logic           sh_c_q, sh_c_d;
    logic           sh_o_q, sh_o_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [W-1:0]   res_q, res_d;
    logic [W-1:0]   res_hi_q, res_hi_d;
    logic [3:0]     flags_q, flags_d;

    alu_op_e        op_in;
    launch_e        launch_kind;
    logic [W:0]     arith;
    logic [W-1:0]   imm_res;
    logic [W-1:0]   imm_hi;
    logic           imm_cf;
    logic           imm_of;
    logic [3:0]     imm_flags;
    logic [SHW-1:0] n_sat;
    logic [SHW-1:0] n_rot;
    logic [SHW-1:0] n_rtc;
    logic [SHW-1:0] shift_n;
    logic           shift_o0;

    logic [W-1:0]   step_v;
    logic           step_c;
    logic           step_o;

    logic           md_load;
    logic           md_step;
    logic [W-1:0]   md_lo;
    logic [W-1:0]   md_hi;
    logic           md_done;
    logic           md_flag;

    // Decode the incoming operation: immediate result for single-cycle cases,
    // otherwise the shift count / launch kind for the iterative paths
    always_comb begin
        op_in       = alu_op_e'(opsel);
        launch_kind = LAUNCH_DONE;
        arith       = '0;
        imm_res     = '0;
        imm_hi      = '0;
        imm_cf      = Cflag;
        imm_of      = Oflag;
        shift_n     = '0;
        shift_o0    = Oflag;
        n_sat       = (srcB >= W) ? SHW'(W) : srcB[SHW-1:0];
        n_rot       = SHW'(srcB % W);
        n_rtc       = SHW'(srcB % (W + 1));
        case (op_in)
            ALU_ADD: begin
                arith   = {1'b0, srcA} + {1'b0, srcB};
                imm_res = arith[W-1:0];
                imm_cf  = arith[W];
                imm_of  = (srcA[W-1] == srcB[W-1]) && (arith[W-1] != srcA[W-1]);
            end
            ALU_SUB: begin
                arith   = {1'b0, srcA} - {1'b0, srcB};
                imm_res = arith[W-1:0];
                imm_cf  = arith[W];
                imm_of  = (srcA[W-1] != srcB[W-1]) && (arith[W-1] != srcA[W-1]);
            end
            ALU_INC: begin
                arith   = {1'b0, srcA} + {{W{1'b0}}, 1'b1};
                imm_res = arith[W-1:0];
                imm_cf  = arith[W];
                imm_of  = !srcA[W-1] && arith[W-1];
            end
            ALU_DEC: begin
                arith   = {1'b0, srcA} - {{W{1'b0}}, 1'b1};
                imm_res = arith[W-1:0];
                imm_cf  = arith[W];
                imm_of  = srcA[W-1] && !arith[W-1];
            end
            ALU_AND: imm_res = srcA & srcB;
            ALU_OR:  imm_res = srcA | srcB;
            ALU_XOR: imm_res = srcA ^ srcB;
            ALU_NOT: imm_res = ~srcA;
            ALU_NEG: imm_res = -srcA;
            ALU_MUL: launch_kind = LAUNCH_MULDIV;
            ALU_DIV: begin
                if (srcB == '0) begin
                    imm_res = '1;
                    imm_hi  = srcA;
                    imm_of  = 1'b1;
                end else begin
                    launch_kind = LAUNCH_MULDIV;
                end
            end
            ALU_RSL, ALU_LSL, ALU_RSA, ALU_LSA: begin
                shift_n = n_sat;
                imm_res = srcA;
                if (op_in == ALU_LSA) shift_o0 = 1'b0;
                if (shift_n != '0) launch_kind = LAUNCH_SHIFT;
            end
            ALU_RSR, ALU_LSR: begin
                shift_n = n_rot;
                imm_res = srcA;
                if (shift_n != '0) launch_kind = LAUNCH_SHIFT;
            end
            ALU_RSC, ALU_LSC: begin
                shift_n = n_rtc;
                imm_res = srcA;
                if (shift_n != '0) launch_kind = LAUNCH_SHIFT;
            end
            default: imm_res = '0;
        endcase
        imm_flags = pack_flags(imm_res == '0, imm_res[W-1], imm_cf, imm_of);
    end

    // One-bit shift/rotate step on the working register; rotate-through-carry
    // treats {carry, value} as a W+1 bit ring
    always_comb begin
        step_v = sh_v_q;
        step_c = sh_c_q;
        step_o = sh_o_q;
        case (op_q)
            ALU_RSL: begin
                step_c = sh_v_q[0];
                step_v = {1'b0, sh_v_q[W-1:1]};
            end
            ALU_LSL: begin
                step_c = sh_v_q[W-1];
                step_v = {sh_v_q[W-2:0], 1'b0};
            end
            ALU_RSA: begin
                step_c = sh_v_q[0];
                step_v = {sh_v_q[W-1], sh_v_q[W-1:1]};
            end
            ALU_LSA: begin
                step_c = sh_v_q[W-1];
                step_v = {sh_v_q[W-2:0], 1'b0};
                if (sh_v_q[W-1] != sh_v_q[W-2]) step_o = 1'b1;
            end
            ALU_RSR: begin
                step_c = sh_v_q[0];
                step_v = {sh_v_q[0], sh_v_q[W-1:1]};
            end
            ALU_LSR: begin
                step_c = sh_v_q[W-1];
                step_v = {sh_v_q[W-2:0], sh_v_q[W-1]};
            end
            ALU_RSC: begin
                step_c = sh_v_q[0];
                step_v = {sh_c_q, sh_v_q[W-1:1]};
            end
            ALU_LSC: begin
                step_c = sh_v_q[W-1];
                step_v = {sh_v_q[W-2:0], sh_c_q};
            end
            default: step_v = sh_v_q;
        endcase
    end

    assign md_flag = (op_q == ALU_MUL) && (md_hi != '0);

    // Control FSM: accept in IDLE or DONE, iterate in EXEC, commit results on entry to DONE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sh_v_d   = sh_v_q;
        sh_c_d   = sh_c_q;
        sh_o_d   = sh_o_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        md_load  = 1'b0;
        md_step  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    op_d = op_in;
                    case (launch_kind)
                        LAUNCH_SHIFT: begin
                            state_d = ST_EXEC;
                            sh_v_d  = srcA;
                            sh_c_d  = Cflag;
                            sh_o_d  = shift_o0;
                            cnt_d   = shift_n;
                        end
                        LAUNCH_MULDIV: begin
                            state_d = ST_EXEC;
                            md_load = 1'b1;
                        end
                        default: begin
                            state_d  = ST_DONE;
                            res_d    = imm_res;
                            res_hi_d = imm_hi;
                            flags_d  = imm_flags;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                if (is_shift(op_q)) begin
                    sh_v_d = step_v;
                    sh_c_d = step_c;
                    sh_o_d = step_o;
                    cnt_d  = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_d  = ST_DONE;
                        res_d    = step_v;
                        res_hi_d = '0;
                        flags_d  = pack_flags(step_v == '0, step_v[W-1], step_c, step_o);
                    end
                end else begin
                    md_step = 1'b1;
                    if (md_done) begin
                        state_d  = ST_DONE;
                        res_d    = md_lo;
                        res_hi_d = md_hi;
                        flags_d  = pack_flags(md_lo == '0, md_lo[W-1], md_flag, md_flag);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_ADD;
            sh_v_q   <= '0;
            sh_c_q   <= 1'b0;
            sh_o_q   <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sh_v_q   <= sh_v_d;
            sh_c_q   <= sh_c_d;
            sh_o_q   <= sh_o_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
        end
    end

    alu_muldiv #(
        .W(W)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .load    (md_load),
        .is_div  (op_in == ALU_DIV),
        .op_a    (srcA),
        .op_b    (srcB),
        .step    (md_step),
        .lo_next (md_lo),
        .hi_next (md_hi),
        .done    (md_done)
    );

    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign flag_next = flags_q;
    assign busy      = (state_q != ST_IDLE);
    assign ready     = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=16): directed cases plus randomized
// operations compared against a word-level arithmetic reference model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  opsel;
    logic [15:0] srcA;
    logic [15:0] srcB;
    logic        Cflag;
    logic        Oflag;
    logic [15:0] res;
    logic [15:0] res_hi;
    logic [3:0]  flag_next;
    logic        busy;
    logic        ready;

    int checks = 0;
    int errors = 0;

    logic [4:0] op_list [19] = '{ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC, ALU_AND,
                                 ALU_OR, ALU_XOR, ALU_NOT, ALU_NEG, ALU_MUL,
                                 ALU_DIV, ALU_RSL, ALU_LSL, ALU_RSA, ALU_LSA,
                                 ALU_RSR, ALU_LSR, ALU_RSC, ALU_LSC};

    alu_seq #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opsel     (opsel),
        .srcA      (srcA),
        .srcB      (srcB),
        .Cflag     (Cflag),
        .Oflag     (Oflag),
        .res       (res),
        .res_hi    (res_hi),
        .flag_next (flag_next),
        .busy      (busy),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word-level reference: result, high half, {ZF,NF,CF,OF} and edges-to-ready
    task automatic refModel(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic o,
                            output logic [15:0] r, output logic [15:0] h,
                            output logic [3:0] f, output int lat);
        logic [63:0] x, y, x2;
        int sa, sb, s, s2, n, m;
        logic cf, of;
        cf = c; of = o; r = '0; h = '0; lat = 1;
        x = '0; y = '0; x2 = '0; s = 0; s2 = 0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            ALU_ADD: begin
                r = a + b; cf = (int'(a) + int'(b)) > 65535;
                s = sa + sb; of = (s > 32767) || (s < -32768);
            end
            ALU_SUB: begin
                r = a - b; cf = (a < b);
                s = sa - sb; of = (s > 32767) || (s < -32768);
            end
            ALU_INC: begin r = a + 16'd1; cf = (a == 16'hFFFF); of = (sa + 1) > 32767; end
            ALU_DEC: begin r = a - 16'd1; cf = (a == 16'h0000); of = (sa - 1) < -32768; end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_NOT: r = ~a;
            ALU_NEG: r = 16'd0 - a;
            ALU_MUL: begin
                x = 64'(a) * 64'(b); r = x[15:0]; h = x[31:16];
                cf = (h != 0); of = cf; lat = 17;
            end
            ALU_DIV: begin
                if (b == 0) begin
                    r = 16'hFFFF; h = a; of = 1'b1;
                end else begin
                    r = a / b; h = a % b; cf = 1'b0; of = 1'b0; lat = 17;
                end
            end
            ALU_RSL, ALU_LSL, ALU_RSA, ALU_LSA: begin
                n = (b > 16) ? 16 : int'(b);
                r = a;
                if (n > 0) begin
                    lat = 1 + n;
                    if (op == ALU_RSL) begin
                        r = 16'(64'(a) >> n); cf = a[n-1];
                    end else if (op == ALU_RSA) begin
                        s = sa >>> n; s2 = sa >>> (n - 1);
                        r = s[15:0]; cf = s2[0];
                    end else begin
                        x = 64'(a) << n; r = x[15:0]; cf = x[16];
                        if (op == ALU_LSA) begin
                            of = 1'b0;
                            for (int k = 1; k <= n; k++) begin
                                y  = 64'(a) << k;
                                x2 = 64'(a) << (k - 1);
                                if (y[15] != x2[15]) of = 1'b1;
                            end
                        end
                    end
                end
            end
            ALU_RSR, ALU_LSR: begin
                m = int'(b) % 16;
                r = a;
                if (m > 0) begin
                    lat = 1 + m;
                    if (op == ALU_RSR) begin
                        x = (64'(a) >> m) | (64'(a) << (16 - m)); r = x[15:0]; cf = r[15];
                    end else begin
                        x = (64'(a) << m) | (64'(a) >> (16 - m)); r = x[15:0]; cf = r[0];
                    end
                end
            end
            ALU_RSC, ALU_LSC: begin
                m = int'(b) % 17;
                r = a;
                y = {47'b0, c, a};
                if (m > 0) begin
                    lat = 1 + m;
                    if (op == ALU_RSC) x = (y >> m) | (y << (17 - m));
                    else               x = (y << m) | (y >> (17 - m));
                    r = x[15:0]; cf = x[16];
                end
            end
            default: r = '0;
        endcase
        f = {r == 16'd0, r[15], cf, of};
    endtask

    // Launch one operation, scramble the inputs after acceptance, wait for ready and check
    task automatic applyStimulus(input string tag, input logic [4:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic c, input logic o,
                                 input bit chained);
        logic [15:0] er, eh;
        logic [3:0]  ef;
        int          elat, lat;
        refModel(op, a, b, c, o, er, eh, ef, elat);
        if (!chained) begin
            @(negedge clk);
            checkOutput({tag, "_idle"}, {30'b0, busy, ready}, 32'd0);
        end
        opsel = op; srcA = a; srcB = b; Cflag = c; Oflag = o; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        opsel = 5'($urandom); srcA = 16'($urandom); srcB = 16'($urandom);
        Cflag = 1'($urandom); Oflag = 1'($urandom);
        lat = 1;
        while (ready !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'(elat));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_res"}, 32'(res), 32'(er));
        checkOutput({tag, "_hi"}, 32'(res_hi), 32'(eh));
        checkOutput({tag, "_flags"}, 32'(flag_next), 32'(ef));
    endtask

    // MUL in flight, a stray start is ignored, then reset aborts it
    task automatic resetAbort();
        logic seen;
        @(negedge clk);
        opsel = ALU_MUL; srcA = 16'h1234; srcB = 16'h0100; Cflag = 1'b0; Oflag = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); opsel = ALU_ADD; srcA = 16'd1; srcB = 16'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd1);
        checkOutput("abort_noready", 32'(ready), 32'd0);
        rst = 1'b1; opsel = ALU_ADD; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checkOutput("abort_rst_busy", 32'(busy), 32'd0);
        checkOutput("abort_rst_ready", 32'(ready), 32'd0);
        checkOutput("abort_rst_res", 32'(res), 32'd0);
        checkOutput("abort_rst_hi", 32'(res_hi), 32'd0);
        checkOutput("abort_rst_flags", 32'(flag_next), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ready === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checkOutput("abort_quiet", 32'(seen), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opsel = '0; srcA = '0; srcB = '0; Cflag = 1'b0; Oflag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_res", 32'(res), 32'd0);
        checkOutput("reset_hi", 32'(res_hi), 32'd0);
        checkOutput("reset_flags", 32'(flag_next), 32'd0);
        checkOutput("reset_hs", {30'b0, busy, ready}, 32'd0);
        rst = 1'b0;

        // Directed cases, including count saturation/modulo boundaries
        applyStimulus("add_ovf",  ALU_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        checkOutput("add_ovf_const", 32'(flag_next), 32'b0101);
        applyStimulus("sub_brw",  ALU_SUB, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0);
        applyStimulus("inc_ovf",  ALU_INC, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus("dec_zero", ALU_DEC, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        applyStimulus("dec_ovf",  ALU_DEC, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0);
        applyStimulus("neg_pass", ALU_NEG, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
        applyStimulus("rsl1",     ALU_RSL, 16'h0005, 16'h0001, 1'b0, 1'b0, 1'b0);
        applyStimulus("rsc1",     ALU_RSC, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);
        applyStimulus("rsl_sat",  ALU_RSL, 16'h8001, 16'd20,   1'b0, 1'b1, 1'b0);
        applyStimulus("lsa_ovf",  ALU_LSA, 16'h4000, 16'd2,    1'b0, 1'b0, 1'b0);
        applyStimulus("rsa3",     ALU_RSA, 16'h8000, 16'd3,    1'b0, 1'b1, 1'b0);
        applyStimulus("rsr_mod",  ALU_RSR, 16'h1234, 16'd16,   1'b1, 1'b1, 1'b0);
        applyStimulus("lsr5",     ALU_LSR, 16'h8421, 16'd5,    1'b0, 1'b0, 1'b0);
        applyStimulus("lsc_mod",  ALU_LSC, 16'hA5A5, 16'd17,   1'b1, 1'b0, 1'b0);
        applyStimulus("rsc16",    ALU_RSC, 16'h1234, 16'd16,   1'b1, 1'b0, 1'b0);
        applyStimulus("lsl0",     ALU_LSL, 16'h00F0, 16'd0,    1'b1, 1'b1, 1'b0);
        applyStimulus("mul",      ALU_MUL, 16'h1234, 16'h0100, 1'b0, 1'b0, 1'b0);
        applyStimulus("mul_max",  ALU_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus("div",      ALU_DIV, 16'd100,  16'd7,    1'b1, 1'b1, 1'b0);
        applyStimulus("div0",     ALU_DIV, 16'h00AB, 16'h0000, 1'b1, 1'b0, 1'b0);
        applyStimulus("undef",    5'd15,   16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0);

        // Back-to-back: next op accepted in the DONE cycle of the previous one
        applyStimulus("b2b_mul",  ALU_MUL, 16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0);
        applyStimulus("b2b_add",  ALU_ADD, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        applyStimulus("b2b_sh",   ALU_LSL, 16'h0F0F, 16'd3,    1'b0, 1'b0, 1'b0);
        applyStimulus("b2b_sub",  ALU_SUB, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1);

        // Randomized operations
        for (int i = 0; i < 150; i++) begin
            int          sel;
            logic [4:0]  op;
            logic [15:0] a, b;
            sel = int'($urandom_range(0, 20));
            if (sel < 19) op = op_list[sel];
            else          op = 5'($urandom_range(11, 23));
            a = 16'($urandom);
            b = 16'($urandom);
            if (op[4:3] == 2'b11 && $urandom_range(0, 1) == 1) b = 16'($urandom_range(0, 20));
            if (op == ALU_DIV && $urandom_range(0, 7) == 0) b = 16'd0;
            applyStimulus($sformatf("rnd%0d", i), op, a, b, 1'($urandom), 1'($urandom),
                          bit'($urandom_range(0, 3) == 0));
        end

        applyStimulus("pre_abort", ALU_OR, 16'h00FF, 16'hFF00, 1'b1, 1'b1, 1'b0);
        resetAbort();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU; the next generation of the datapath ALU. Keeps the single-cycle arithmetic/logic set and adds iterative shifts/rotates, an unsigned shift-add multiply and a restoring divide behind a start/busy/ready handshake. Sits between the register-file read stage and write-back; the control FSM stalls on `busy` and commits `res`, `res_hi` and `flag_next` on `ready`.

## Interface
- `W`, 16, datapath width (≥4)
- `SHW`, derived localparam, clog2(W)+1, shift-count width
- `clk` in 1, clock
- `rst` in 1, synchronous active-high reset
- `start` in 1, launch operation; sampled only when `busy`=0
- `opsel` in 5, operation code from shared opsel definitions
- `srcA`, `srcB` in W, operands; sampled at the accepting edge only
- `Cflag`, `Oflag` in 1, current carry/overflow; sampled with operands
- `res` out W, result (MUL low half, DIV quotient)
- `res_hi` out W, MUL high half / DIV remainder; 0 for other ops
- `flag_next` out 4, {ZF,NF,CF,OF} at bits 3..0
- `busy` out 1, operation in flight
- `ready` out 1, one-cycle pulse; outputs valid from this cycle on

## Operation
- States: IDLE, EXEC, DONE. IDLE+start → EXEC (or DONE for single-cycle ops); EXEC counts down to DONE; DONE pulses `ready`, returns to IDLE.
- `start` while `busy`=1 ignored. `start` in the DONE cycle accepted (back-to-back).
- Single-cycle: ADD, SUB, INC, DEC, AND, OR, XOR, NOT, NEG. Arithmetic in W+1 bits; CF = bit W; OF = signed overflow (ADD/SUB as classic sign rule, INC: A≥0 → res<0, DEC: A<0 → res≥0). Logic ops and NEG pass Cflag/Oflag.
- Shifts (RSL, LSL, RSA, LSA, RSR, LSR, RSC, LSC): one bit per EXEC cycle. Count n = srcB saturated to W for logical/arithmetic, srcB mod W for RSR/LSR, srcB mod (W+1) for RSC/LSC. CF = last bit shifted out (rotates: last bit moved across the end); RSC/LSC rotate {Cflag,srcA} as W+1 bits. LSA: OF=1 if sign bit changed at any step; other shifts pass Oflag. n=0: res=srcA, CF/OF pass.
- MUL: unsigned W×W→2W shift-add, W iterations; CF=OF=(res_hi≠0).
- DIV: unsigned restoring, W iterations; CF=OF=0. srcB=0: no iteration, res=all-ones, res_hi=srcA, OF=1, CF=Cflag.
- All ops: ZF=(res==0), NF=res[W-1] (res_hi ignored).
- Undefined opsel: res=0, res_hi=0, ZF=1, NF=0, CF/OF pass; single-cycle.
- Outputs registered; hold last value until the next `ready`.

## Timing
- Accept edge t (start=1, busy=0). `busy`=1 from t+1 until `ready` cycle inclusive.
- `ready` at t+1 for single-cycle ops, shift n=0, DIV by zero, undefined opsel.
- `ready` at t+1+n for shifts, t+1+W for MUL/DIV.
- Reset: state IDLE, `busy`=0, `ready`=0, `res`=0, `res_hi`=0, `flag_next`=0; effective edge after `rst` sampled high.
- `rst` mid-operation aborts: no `ready` pulse, outputs return to reset values; `start` same cycle as `rst` ignored.

## Structure
- Shared opsel definitions gain `ALU_MUL`, `ALU_DIV`; shift codes stay 24..31; flag index defines (ZF=3, NF=2, CF=1, OF=0) move to the same shared file.
- One sub-module: `alu_muldiv`, iterative multiply/divide datapath (partial-product/remainder registers, step enable, done). Shifts and single-cycle ops stay in the top FSM.

## Test plan (W=16)
- ADD 0x7FFF+0x0001, start at t → `ready` t+1, res=0x8000, flag_next=0b0101 (NF, OF).
- RSL 0x0005 by 1 → `ready` t+2, res=0x0002, CF=1; RSC 0x0001 by 1, Cflag=1 → res=0x8000, CF=1, NF=1.
- MUL 0x1234×0x0100 → `ready` t+17, res=0x3400, res_hi=0x0012, CF=OF=1.
- DIV 100/7 → `ready` t+17, res=14, res_hi=2; DIV 0x00AB/0 → `ready` t+1, res=0xFFFF, res_hi=0x00AB, OF=1.
- MUL started, second `start` (ADD) at t+3 ignored; `rst` at t+5 → `busy`=0 at t+6, no `ready`, res=0, flag_next=0.
- ADD accepted in DONE cycle of previous op → two `ready` pulses on consecutive cycles, each with correct result.
